// File: rtl/rggen_apb_host_adapter.sv
// -----------------------------------------------------------------------------
// rggen_apb_host_adapter
//
// APB completer that converts each host access into one single-beat request
// on the internal register access bus consumed by the generated register
// block. It rejects accesses outside the decoded window without touching the
// register block. A response timeout keeps a hung register block from stalling
// the APB host indefinitely.
//
// Parameters
//   ADDRESS_WIDTH  width of i_paddr / o_bus_address
//   DATA_WIDTH     data width, 32 or 64
//   TOTAL_SIZE     bytes decoded by the register block (0 .. TOTAL_SIZE-1)
//   TIMEOUT_CYCLES maximum o_bus_valid cycles without i_bus_ready, 0 = none
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   i_psel .. i_pstrb    APB request side
//   o_pready, o_prdata,  APB completion; data and error are only non-zero
//   o_pslverr            while o_pready is high
//   o_bus_*              register access request, held while o_bus_valid
//   i_bus_ready,         register block completion, sampled only while a
//   i_bus_read_data,     request is outstanding
//   i_bus_error
//
// All outputs come straight from flops. The FSM is IDLE -> BUS -> RESP -> IDLE,
// with out-of-range accesses taking IDLE -> RESP directly.
// -----------------------------------------------------------------------------
module rggen_apb_host_adapter #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TOTAL_SIZE     = 256,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    // APB completer
    input  logic                      i_psel,
    input  logic                      i_penable,
    input  logic [ADDRESS_WIDTH-1:0]  i_paddr,
    input  logic                      i_pwrite,
    input  logic [DATA_WIDTH-1:0]     i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
    output logic                      o_pready,
    output logic [DATA_WIDTH-1:0]     o_prdata,
    output logic                      o_pslverr,
    // Register access bus
    output logic                      o_bus_valid,
    output logic                      o_bus_write,
    output logic [ADDRESS_WIDTH-1:0]  o_bus_address,
    output logic [DATA_WIDTH-1:0]     o_bus_write_data,
    output logic [DATA_WIDTH-1:0]     o_bus_write_mask,
    input  logic                      i_bus_ready,
    input  logic [DATA_WIDTH-1:0]     i_bus_read_data,
    input  logic                      i_bus_error
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB_W  = $clog2(STRB_W);

    // Clears the byte-offset bits so the register block always sees a
    // word-aligned address.
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
        ~ADDRESS_WIDTH'((1 << LSB_W) - 1);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           tmo_cnt_q, tmo_cnt_d;

    logic                       bus_valid_q, bus_valid_d;
    logic                       bus_write_q, bus_write_d;
    logic [ADDRESS_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]      bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0]      bus_mask_q, bus_mask_d;
    logic                       pready_q, pready_d;
    logic [DATA_WIDTH-1:0]      prdata_q, prdata_d;
    logic                       pslverr_q, pslverr_d;

    logic                       access_start;
    logic                       out_of_range;
    logic                       bus_done;
    logic                       bus_timeout;

    // Byte strobes to a bit mask: byte k of the mask is all ones when
    // strobe k is set.
    function automatic logic [DATA_WIDTH-1:0] expand_strobe(input logic [STRB_W-1:0] strb);
        logic [DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int k = 0; k < STRB_W; k++) begin
            mask[k*8 +: 8] = {8{strb[k]}};
        end
        return mask;
    endfunction

    // The access phase is only recognised in IDLE; psel/penable changes
    // during BUS or RESP are deliberately ignored so an access always
    // completes with exactly one pready pulse.
    assign access_start = (state_q == ST_IDLE) && i_psel && i_penable;

    // Compare in 64 bits so TOTAL_SIZE may equal 2**ADDRESS_WIDTH.
    assign out_of_range = 64'(i_paddr) >= 64'(TOTAL_SIZE);

    assign bus_done = (state_q == ST_BUS) && i_bus_ready;

    // Ready in the final allowed cycle still wins, hence the !i_bus_ready.
    assign bus_timeout = (TIMEOUT_CYCLES != 0) && (state_q == ST_BUS) &&
                         !i_bus_ready && (tmo_cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (access_start) begin
                    state_d = out_of_range ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (bus_done || bus_timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus_valid_d = 1'b0;
        bus_write_d = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        bus_mask_d  = '0;
        pready_d    = 1'b0;
        prdata_d    = '0;
        pslverr_d   = 1'b0;
        tmo_cnt_d   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (access_start) begin
                    if (out_of_range) begin
                        // Answered locally; the register block never sees it.
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        bus_valid_d = 1'b1;
                        bus_write_d = i_pwrite;
                        bus_addr_d  = i_paddr & ALIGN_MASK;
                        // Reads present zero data and a full mask.
                        bus_wdata_d = i_pwrite ? i_pwdata : '0;
                        bus_mask_d  = i_pwrite ? expand_strobe(i_pstrb) : '1;
                    end
                end
            end
            ST_BUS: begin
                if (bus_done) begin
                    pready_d  = 1'b1;
                    prdata_d  = bus_write_q ? '0 : i_bus_read_data;
                    pslverr_d = i_bus_error;
                end else if (bus_timeout) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                end else begin
                    // Still waiting: hold the request and count the cycle.
                    bus_valid_d = 1'b1;
                    bus_write_d = bus_write_q;
                    bus_addr_d  = bus_addr_q;
                    bus_wdata_d = bus_wdata_q;
                    bus_mask_d  = bus_mask_q;
                    tmo_cnt_d   = tmo_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // RESP: everything returns to zero after the single pready.
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output and timeout counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_valid_q <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_mask_q  <= '0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            bus_valid_q <= bus_valid_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_mask_q  <= bus_mask_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign o_bus_valid      = bus_valid_q;
    assign o_bus_write      = bus_write_q;
    assign o_bus_address    = bus_addr_q;
    assign o_bus_write_data = bus_wdata_q;
    assign o_bus_write_mask = bus_mask_q;
    assign o_pready         = pready_q;
    assign o_prdata         = prdata_q;
    assign o_pslverr        = pslverr_q;

endmodule

// File: tb/tb_rggen_apb_host_adapter.sv
// -----------------------------------------------------------------------------
// Directed testbench for rggen_apb_host_adapter (TIMEOUT_CYCLES = 4).
// Inputs change 1ns after the rising edge and outputs are sampled there too,
// so every observation reflects the flops updated by the preceding edge.
// -----------------------------------------------------------------------------
module tb_rggen_apb_host_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        bus_valid, bus_write;
    logic [15:0] bus_address;
    logic [31:0] bus_wdata, bus_mask;
    logic        bus_ready, bus_error;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rggen_apb_host_adapter #(
        .ADDRESS_WIDTH  (16),
        .DATA_WIDTH     (32),
        .TOTAL_SIZE     (256),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_psel           (psel),
        .i_penable        (penable),
        .i_paddr          (paddr),
        .i_pwrite         (pwrite),
        .i_pwdata         (pwdata),
        .i_pstrb          (pstrb),
        .o_pready         (pready),
        .o_prdata         (prdata),
        .o_pslverr        (pslverr),
        .o_bus_valid      (bus_valid),
        .o_bus_write      (bus_write),
        .o_bus_address    (bus_address),
        .o_bus_write_data (bus_wdata),
        .o_bus_write_mask (bus_mask),
        .i_bus_ready      (bus_ready),
        .i_bus_read_data  (bus_rdata),
        .i_bus_error      (bus_error)
    );

    // What one access looked like from outside. lat is the cycle (1 = the
    // cycle after penable was sampled) in which pready was first seen.
    typedef struct {
        int          nvalid;
        int          lat;
        int          npready;
        logic [31:0] prdata;
        logic        slverr;
        logic [15:0] addr;
        logic [31:0] mask;
        logic [31:0] wdata;
        logic        wr;
        logic        stable;
    } res_t;

    // Drives one APB access and plays the register block.
    // wait_cyc: number of valid cycles before ready (-1 = never ready).
    // drop_at : valid cycle in which psel/penable are illegally dropped (0 = never).
    // tail    : cycles to keep observing after pready (0 = return at once).
    task automatic run_access(input logic [15:0] addr, input logic wr,
                              input logic [31:0] wd, input logic [3:0] st,
                              input int wait_cyc, input logic [31:0] rd,
                              input logic er, input int drop_at, input int tail,
                              output res_t r);
        r.nvalid = 0; r.lat = -1; r.npready = 0; r.prdata = '0; r.slverr = 1'b0;
        r.addr = '0; r.mask = '0; r.wdata = '0; r.wr = 1'b0; r.stable = 1'b1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 30; c++) begin
            if (bus_valid) begin
                if (r.nvalid == 0) begin
                    r.addr = bus_address; r.mask = bus_mask;
                    r.wdata = bus_wdata; r.wr = bus_write;
                end else if (bus_address !== r.addr || bus_mask !== r.mask ||
                             bus_wdata !== r.wdata || bus_write !== r.wr) begin
                    r.stable = 1'b0;
                end
                r.nvalid++;
                if (drop_at == r.nvalid) begin
                    psel = 1'b0; penable = 1'b0;
                end
                if (wait_cyc >= 0 && r.nvalid - 1 == wait_cyc) begin
                    bus_ready = 1'b1; bus_rdata = rd; bus_error = er;
                end else begin
                    bus_ready = 1'b0; bus_rdata = 32'hBAD0_BAD0; bus_error = 1'b1;
                end
            end else begin
                bus_ready = 1'b0; bus_rdata = 32'hBAD0_BAD0; bus_error = 1'b1;
            end
            if (pready) begin
                r.npready++;
                if (r.lat < 0) begin
                    r.lat = c; r.prdata = prdata; r.slverr = pslverr;
                end
                psel = 1'b0; penable = 1'b0;
            end
            if (r.lat >= 0 && c >= r.lat + tail) break;
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        bus_ready = 1'b0; bus_error = 1'b0; bus_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0;
        bus_ready = 1'b0; bus_rdata = '0; bus_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus_valid, bus_write, pready, pslverr} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b required 0000", {bus_valid, bus_write, pready, pslverr});
        end
        total++;
        if (prdata !== 32'h0 || bus_address !== 16'h0) begin
            bad++; $display("FAIL reset_data: prdata=%h addr=%h required 0", prdata, bus_address);
        end
        total++;
        if (bus_wdata !== 32'h0 || bus_mask !== 32'h0) begin
            bad++; $display("FAIL reset_bus: wdata=%h mask=%h required 0", bus_wdata, bus_mask);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        // Setup phase without penable must not start anything.
        begin
            int seen;
            seen = 0;
            psel = 1'b1; penable = 1'b0; paddr = 16'h0010; pwrite = 1'b1;
            repeat (4) begin
                @(posedge clk); #1;
                if (bus_valid || pready) seen++;
            end
            psel = 1'b0;
            total++;
            if (seen !== 0) begin
                bad++; $display("FAIL setup_only: activity cycles=%0d required 0", seen);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        res_t r;
        run_access(16'h0010, 1'b1, 32'hA5A5_1234, 4'b0101, 0, 32'hFFFF_FFFF, 1'b0, 0, 8, r);
        total++;
        if (r.mask !== 32'h00FF_00FF) begin
            bad++; $display("FAIL wr_mask: got %h required 00ff00ff", r.mask);
        end
        total++;
        if (r.addr !== 16'h0010 || r.wr !== 1'b1 || r.wdata !== 32'hA5A5_1234) begin
            bad++; $display("FAIL wr_req: addr=%h wr=%b wdata=%h required 0010 1 a5a51234", r.addr, r.wr, r.wdata);
        end
        total++;
        if (r.nvalid !== 1 || r.lat !== 2 || r.npready !== 1) begin
            bad++; $display("FAIL wr_timing: nvalid=%0d lat=%0d npready=%0d required 1 2 1", r.nvalid, r.lat, r.npready);
        end
        total++;
        if (r.slverr !== 1'b0 || r.prdata !== 32'h0) begin
            bad++; $display("FAIL wr_resp: slverr=%b prdata=%h required 0 0", r.slverr, r.prdata);
        end
        // Unaligned address and the other strobe pattern.
        run_access(16'h0007, 1'b1, 32'h1122_3344, 4'b1010, 0, 32'h0, 1'b0, 0, 2, r);
        total++;
        if (r.addr !== 16'h0004 || r.mask !== 32'hFF00_FF00) begin
            bad++; $display("FAIL wr_mask2: addr=%h mask=%h required 0004 ff00ff00", r.addr, r.mask);
        end
    endtask

    task automatic test_read_wait();
        res_t r;
        run_access(16'h0023, 1'b0, 32'h5555_5555, 4'b1111, 3, 32'hDEAD_BEEF, 1'b0, 0, 8, r);
        total++;
        if (r.addr !== 16'h0020 || r.wr !== 1'b0) begin
            bad++; $display("FAIL rd_addr: addr=%h wr=%b required 0020 0", r.addr, r.wr);
        end
        total++;
        if (r.mask !== 32'hFFFF_FFFF || r.wdata !== 32'h0) begin
            bad++; $display("FAIL rd_req: mask=%h wdata=%h required ffffffff 0", r.mask, r.wdata);
        end
        total++;
        if (r.nvalid !== 4 || r.lat !== 5 || r.npready !== 1 || r.stable !== 1'b1) begin
            bad++; $display("FAIL rd_timing: nvalid=%0d lat=%0d npready=%0d stable=%b required 4 5 1 1", r.nvalid, r.lat, r.npready, r.stable);
        end
        total++;
        if (r.prdata !== 32'hDEAD_BEEF || r.slverr !== 1'b0) begin
            bad++; $display("FAIL rd_resp: prdata=%h slverr=%b required deadbeef 0", r.prdata, r.slverr);
        end
    endtask

    task automatic test_out_of_range();
        res_t r;
        run_access(16'h0100, 1'b0, 32'h0, 4'b1111, 0, 32'h1234_5678, 1'b0, 0, 8, r);
        total++;
        if (r.nvalid !== 0) begin
            bad++; $display("FAIL oor_valid: valid cycles=%0d required 0", r.nvalid);
        end
        total++;
        if (r.lat !== 1 || r.npready !== 1) begin
            bad++; $display("FAIL oor_timing: lat=%0d npready=%0d required 1 1", r.lat, r.npready);
        end
        total++;
        if (r.slverr !== 1'b1 || r.prdata !== 32'h0) begin
            bad++; $display("FAIL oor_resp: slverr=%b prdata=%h required 1 0", r.slverr, r.prdata);
        end
        // Last legal byte goes to the bus.
        run_access(16'h00FF, 1'b0, 32'h0, 4'b1111, 0, 32'h0000_00AB, 1'b0, 0, 2, r);
        total++;
        if (r.nvalid !== 1 || r.addr !== 16'h00FC || r.slverr !== 1'b0 || r.prdata !== 32'hAB) begin
            bad++; $display("FAIL edge_in_range: nvalid=%0d addr=%h slverr=%b prdata=%h required 1 00fc 0 ab", r.nvalid, r.addr, r.slverr, r.prdata);
        end
    endtask

    task automatic test_timeout();
        res_t r;
        run_access(16'h0030, 1'b0, 32'h0, 4'b1111, -1, 32'h0, 1'b0, 0, 8, r);
        total++;
        if (r.nvalid !== 4 || r.lat !== 5 || r.npready !== 1) begin
            bad++; $display("FAIL tmo_timing: nvalid=%0d lat=%0d npready=%0d required 4 5 1", r.nvalid, r.lat, r.npready);
        end
        total++;
        if (r.slverr !== 1'b1 || r.prdata !== 32'h0) begin
            bad++; $display("FAIL tmo_resp: slverr=%b prdata=%h required 1 0", r.slverr, r.prdata);
        end
        // Ready in the last allowed cycle beats the timeout.
        run_access(16'h0034, 1'b0, 32'h0, 4'b1111, 3, 32'h1234_5678, 1'b0, 0, 8, r);
        total++;
        if (r.nvalid !== 4 || r.npready !== 1 || r.slverr !== 1'b0 || r.prdata !== 32'h1234_5678) begin
            bad++; $display("FAIL tmo_ready_last: nvalid=%0d npready=%0d slverr=%b prdata=%h required 4 1 0 12345678", r.nvalid, r.npready, r.slverr, r.prdata);
        end
        run_access(16'h0038, 1'b0, 32'h0, 4'b1111, 3, 32'h0000_0077, 1'b1, 0, 2, r);
        total++;
        if (r.slverr !== 1'b1 || r.prdata !== 32'h77) begin
            bad++; $display("FAIL tmo_ready_last_err: slverr=%b prdata=%h required 1 77", r.slverr, r.prdata);
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        run_access(16'h0040, 1'b1, 32'hCAFE_0001, 4'b1111, 0, 32'h0, 1'b1, 0, 0, r);
        total++;
        if (r.slverr !== 1'b1 || r.lat !== 2) begin
            bad++; $display("FAIL b2b_wr_err: slverr=%b lat=%0d required 1 2", r.slverr, r.lat);
        end
        run_access(16'h0044, 1'b0, 32'h0, 4'b1111, 0, 32'h600D_CAFE, 1'b0, 0, 8, r);
        total++;
        if (r.slverr !== 1'b0 || r.prdata !== 32'h600D_CAFE || r.lat !== 2 || r.npready !== 1) begin
            bad++; $display("FAIL b2b_rd: slverr=%b prdata=%h lat=%0d npready=%0d required 0 600dcafe 2 1", r.slverr, r.prdata, r.lat, r.npready);
        end
    endtask

    task automatic test_protocol_violation();
        res_t r;
        run_access(16'h0008, 1'b0, 32'h0, 4'b1111, 2, 32'h1122_3344, 1'b0, 1, 8, r);
        total++;
        if (r.nvalid !== 3 || r.npready !== 1 || r.prdata !== 32'h1122_3344 || r.slverr !== 1'b0) begin
            bad++; $display("FAIL drop_psel: nvalid=%0d npready=%0d prdata=%h slverr=%b required 3 1 11223344 0", r.nvalid, r.npready, r.prdata, r.slverr);
        end
    endtask

    task automatic test_reset_mid_access();
        res_t r;
        int   act;
        psel = 1'b1; penable = 1'b0; paddr = 16'h0050; pwrite = 1'b0; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus_valid !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: valid=%b required 1", bus_valid);
        end
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus_valid !== 1'b0 || pready !== 1'b0) begin
            bad++; $display("FAIL rstmid_drop: valid=%b pready=%b required 0 0", bus_valid, pready);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        act = 0;
        bus_ready = 1'b1; bus_rdata = 32'hFFFF_0000; bus_error = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (pready || bus_valid) act++;
        end
        bus_ready = 1'b0; bus_error = 1'b0; bus_rdata = '0;
        total++;
        if (act !== 0) begin
            bad++; $display("FAIL rstmid_after: activity cycles=%0d required 0", act);
        end
        run_access(16'h0054, 1'b0, 32'h0, 4'b1111, 1, 32'h0BAD_F00D, 1'b0, 0, 4, r);
        total++;
        if (r.nvalid !== 2 || r.npready !== 1 || r.prdata !== 32'h0BAD_F00D || r.slverr !== 1'b0) begin
            bad++; $display("FAIL rstmid_next: nvalid=%0d npready=%0d prdata=%h slverr=%b required 2 1 0badf00d 0", r.nvalid, r.npready, r.prdata, r.slverr);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_out_of_range();
        test_timeout();
        test_back_to_back();
        test_protocol_violation();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
